// File: rtl/m_cache_refill.sv
// Refill / write-through engine for a write-noallocate cache with 4-word blocks.
// Optional build macro: CACHE_REFILL_CRITICAL_FIRST_EN (requested word is fetched first).
module m_cache_refill #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_req,
    input  logic                  i_wr_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_word_valid,
    output logic [31:0]           o_word,
    output logic                  o_bwe,
    output logic [ADDR_WIDTH-1:0] o_baddr,
    output logic [127:0]          o_bdata,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    input  logic                  i_mem_ack,
    input  logic [31:0]           i_mem_rdata,
    output logic [2:0]            o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_INSTALL = 3'd2,
        S_WR      = 3'd3,
        S_WDONE   = 3'd4
    } state_t;

    // Memory handshake: a beat completes in any cycle where o_mem_req and
    // i_mem_ack are both high; read data is taken in that same cycle, and
    // address/data stay stable until it happens.
    state_t                r_state;
    logic [1:0]            r_beat;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [127:0]          r_buf;
    logic                  r_done;
    logic                  r_word_valid;
    logic [31:0]           r_word;
    logic                  r_bwe;
    logic [ADDR_WIDTH-1:0] r_baddr;
    logic [127:0]          r_bdata;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;

    logic [1:0]   w_next_beat;
    logic [1:0]   w_first_idx;
    logic [1:0]   w_word_idx;
    logic [1:0]   w_next_idx;
    logic [127:0] w_fill;

    assign w_next_beat = r_beat + 2'd1;

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    assign w_first_idx = i_addr[3:2];
    assign w_word_idx  = r_addr[3:2] + r_beat;
    assign w_next_idx  = r_addr[3:2] + w_next_beat;
`else
    assign w_first_idx = 2'd0;
    assign w_word_idx  = r_beat;
    assign w_next_idx  = w_next_beat;
`endif

    // Block buffer with the beat currently on the memory bus merged in.
    always_comb begin
        w_fill = r_buf;
        w_fill[{w_word_idx, 5'd0} +: 32] = i_mem_rdata;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_beat       <= 2'd0;
            r_addr       <= '0;
            r_buf        <= '0;
            r_done       <= 1'b0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
            r_bwe        <= 1'b0;
            r_baddr      <= '0;
            r_bdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_done       <= 1'b0;
            r_word_valid <= 1'b0;
            r_bwe        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_wr_req) begin
                        r_addr      <= i_addr;
                        r_mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_wdata <= i_wdata;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_state     <= S_WR;
                    end else if (i_rd_req) begin
                        r_addr     <= i_addr;
                        r_beat     <= 2'd0;
                        r_mem_addr <= {i_addr[ADDR_WIDTH-1:4], w_first_idx, 2'b00};
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_state    <= S_RD;
                    end
                end
                S_RD: begin
                    if (i_mem_ack) begin
                        r_buf  <= w_fill;
                        r_beat <= w_next_beat;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
                        if (r_beat == 2'd0) begin
                            r_word       <= i_mem_rdata;
                            r_word_valid <= 1'b1;
                        end
`endif
                        if (r_beat == 2'd3) begin
                            r_mem_req <= 1'b0;
                            r_bdata   <= w_fill;
                            r_baddr   <= r_addr;
                            r_bwe     <= 1'b1;
                            r_done    <= 1'b1;
`ifndef CACHE_REFILL_CRITICAL_FIRST_EN
                            r_word       <= w_fill[{r_addr[3:2], 5'd0} +: 32];
                            r_word_valid <= 1'b1;
`endif
                            r_state   <= S_INSTALL;
                        end else begin
                            r_mem_addr <= {r_addr[ADDR_WIDTH-1:4], w_next_idx, 2'b00};
                        end
                    end
                end
                S_INSTALL: r_state <= S_IDLE;
                S_WR: begin
                    if (i_mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_WDONE;
                    end
                end
                S_WDONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready      = (r_state == S_IDLE);
    assign o_done       = r_done;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;
    assign o_bwe        = r_bwe;
    assign o_baddr      = r_baddr;
    assign o_bdata      = r_bdata;
    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_m_cache_refill.sv
// Bench for m_cache_refill: memory model with configurable stalls, queue scoreboard,
// directed timing cases and a randomized refill run.
module tb_m_cache_refill;
  logic         clk = 1'b0;
  logic         rst;
  logic         i_rd_req, i_wr_req;
  logic [31:0]  i_addr, i_wdata;
  logic         o_ready, o_done, o_word_valid, o_bwe;
  logic [31:0]  o_word;
  logic [31:0]  o_baddr;
  logic [127:0] o_bdata;
  logic         o_mem_req, o_mem_we;
  logic [31:0]  o_mem_addr, o_mem_wdata;
  logic         i_mem_ack;
  logic [31:0]  i_mem_rdata;
  logic [2:0]   dbg_state;

  m_cache_refill #(.ADDR_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_rd_req(i_rd_req), .i_wr_req(i_wr_req),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_done(o_done),
    .o_word_valid(o_word_valid), .o_word(o_word), .o_bwe(o_bwe),
    .o_baddr(o_baddr), .o_bdata(o_bdata), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  logic [159:0] exp_blk_q[$];   // {baddr, block}
  logic [31:0]  exp_word_q[$];
  logic [63:0]  exp_wr_q[$];    // {addr, data}
  logic [31:0]  rd_addr_log[$];
  int ack_delay = 0;            // <0: random stalls and stray acks
  int wait_cnt = 0;
  bit pat_a0 = 1'b1;
  int total_bwe = 0, total_done = 0, exp_bwe = 0, exp_done = 0;
  int t_done0, t_done1, t_bwe, t_nbwe, t_wv, t_we_cyc, t_ack, t_unstable;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (pat_a0) return 32'h0000_00A0 + 32'(a[3:2]);
    return (a * 32'h9E37_79B1) ^ (a >> 3) ^ 32'h5A5A_0F0F;
  endfunction

  // memory model: answers a little after each edge
  always @(posedge clk) begin
    #2;
    if (rst) begin
      i_mem_ack = 1'b0;
      wait_cnt = 0;
    end else if (o_mem_req) begin
      if (ack_delay < 0) i_mem_ack = ($urandom_range(0, 2) == 0);
      else if (wait_cnt < ack_delay) begin
        i_mem_ack = 1'b0;
        wait_cnt++;
      end else begin
        i_mem_ack = 1'b1;
        wait_cnt = 0;
      end
    end else begin
      i_mem_ack = (ack_delay < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      wait_cnt = 0;
    end
    i_mem_rdata = o_mem_req ? mem_fn(o_mem_addr) : $urandom;
  end

  // scoreboard monitor
  logic [159:0] m_blk;
  logic [63:0]  m_wr;
  logic [31:0]  m_word;
  always @(negedge clk) begin
    if (!rst) begin
      if (o_bwe) begin
        total_bwe++;
        if (exp_blk_q.size() == 0) check("bwe_unexpected", 160'(o_bwe), 160'd0);
        else begin
          m_blk = exp_blk_q.pop_front();
          check("block", {o_baddr, o_bdata}, m_blk);
        end
      end
      if (o_done) total_done++;
      if (o_word_valid) begin
        if (exp_word_q.size() == 0) check("word_unexpected", 160'(o_word_valid), 160'd0);
        else begin
          m_word = exp_word_q.pop_front();
          check("word", 160'(o_word), 160'(m_word));
        end
      end
      if (o_mem_req && i_mem_ack) begin
        if (o_mem_we) begin
          if (exp_wr_q.size() == 0) check("mem_write_unexpected", 160'(o_mem_we), 160'd0);
          else begin
            m_wr = exp_wr_q.pop_front();
            check("mem_write", 160'({o_mem_addr, o_mem_wdata}), 160'(m_wr));
          end
        end else rd_addr_log.push_back(o_mem_addr);
      end
    end
  end

  // driver tasks
  task automatic push_read(input logic [31:0] a);
    logic [127:0] blk;
    for (int k = 0; k < 4; k++) blk[32*k +: 32] = mem_fn({a[31:4], 2'(k), 2'b00});
    exp_blk_q.push_back({a, blk});
    exp_word_q.push_back(mem_fn({a[31:4], a[3:2], 2'b00}));
    exp_bwe++;
    exp_done++;
  endtask

  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int ndone;
    int need;
    need = int'(rd) + int'(wr);
    if (wr) begin
      exp_wr_q.push_back({a[31:2], 2'b00, d});
      exp_done++;
    end
    if (rd) push_read(a);
    @(posedge clk);
    #1;
    i_addr = a;
    i_wdata = d;
    i_rd_req = rd;
    i_wr_req = wr;
    @(posedge clk);
    ndone = 0;
    t_done0 = -1; t_done1 = -1; t_bwe = -1; t_nbwe = 0; t_wv = -1;
    t_we_cyc = 0; t_ack = -1; t_unstable = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if (o_mem_req && o_mem_we) begin
        t_we_cyc++;
        if (o_mem_addr !== {a[31:2], 2'b00} || o_mem_wdata !== d) t_unstable++;
        if (i_mem_ack) t_ack = c;
      end
      if (o_word_valid && t_wv < 0) t_wv = c;
      if (o_bwe) begin
        t_nbwe++;
        if (t_bwe < 0) t_bwe = c;
      end
      if (o_done) begin
        if (ndone == 0) t_done0 = c; else t_done1 = c;
        if (i_wr_req) i_wr_req = 1'b0; else i_rd_req = 1'b0;
        ndone++;
        if (ndone == need) break;
      end
    end
    if (ndone != need) begin
      check("txn_timeout", 160'(ndone), 160'(need));
      i_rd_req = 1'b0;
      i_wr_req = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 160'(o_ready), 160'd1);
    check({tag, "_pulses"}, 160'({o_done, o_word_valid, o_bwe, o_mem_req, o_mem_we}), 160'd0);
    check({tag, "_data"}, {o_bdata, o_word}, 160'd0);
    check({tag, "_addrs"}, 160'({o_baddr, o_mem_addr, o_mem_wdata}), 160'd0);
  endtask

  int beats;
  int bwe_before;
  logic [31:0] exp_order[4];
  logic [31:0] ra, rw;

  initial begin
    rst = 1'b1; i_rd_req = 1'b0; i_wr_req = 1'b0; i_addr = '0; i_wdata = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // read miss, zero-wait, 0xA0+word
    pat_a0 = 1'b1; ack_delay = 0;
    rd_addr_log.delete();
    txn(1'b1, 1'b0, 32'h0000_1238, 32'h0);
    check("rd_bwe_cycle", 160'(t_bwe), 160'd5);
    check("rd_done_cycle", 160'(t_done0), 160'd5);
    check("rd_bdata", 160'(o_bdata), 160'({32'hA3, 32'hA2, 32'hA1, 32'hA0}));
    check("rd_word_baddr", 160'({o_word, o_baddr}), 160'({32'hA2, 32'h1238}));
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    check("rd_word_valid_cycle", 160'(t_wv), 160'd2);
    exp_order = '{32'h1238, 32'h123C, 32'h1230, 32'h1234};
`else
    check("rd_word_valid_cycle", 160'(t_wv), 160'd5);
    exp_order = '{32'h1230, 32'h1234, 32'h1238, 32'h123C};
`endif
    check("rd_beat_count", 160'(rd_addr_log.size()), 160'd4);
    for (int k = 0; k < 4 && k < rd_addr_log.size(); k++)
      check("rd_beat_addr", 160'(rd_addr_log[k]), 160'(exp_order[k]));
    @(negedge clk);
    check("rd_idle_after", 160'(o_ready), 160'd1);

    // write with 3 stall cycles
    ack_delay = 3;
    txn(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    check("wr_stall_cycles", 160'(t_we_cyc), 160'd4);
    check("wr_stable", 160'(t_unstable), 160'd0);
    check("wr_done_after_ack", 160'(t_done0), 160'(t_ack + 1));
    check("wr_no_bwe", 160'(t_nbwe), 160'd0);

    // zero-wait write, unaligned byte address
    ack_delay = 0;
    txn(1'b0, 1'b1, 32'h0000_0043, 32'h0BAD_F00D);
    check("wr0_done_cycle", 160'(t_done0), 160'd2);

    // simultaneous read and write: write first, read from next IDLE
    txn(1'b1, 1'b1, 32'h0000_2004, 32'h1234_5678);
    check("both_wr_done", 160'(t_done0), 160'd2);
    check("both_rd_done", 160'(t_done1), 160'd8);
    check("both_bwe_cycle", 160'(t_bwe), 160'd8);

    // reset after beat 2 of a refill
    push_read(32'h0000_3000);
    @(posedge clk);
    #1;
    i_addr = 32'h0000_3000;
    i_rd_req = 1'b1;
    beats = 0;
    for (int c = 0; c < 100 && beats < 2; c++) begin
      @(negedge clk);
      if (o_mem_req && !o_mem_we && i_mem_ack) beats++;
    end
    check("rst_beats_seen", 160'(beats), 160'd2);
    @(negedge clk);
    bwe_before = total_bwe;
    rst = 1'b1;
    i_rd_req = 1'b0;
    exp_blk_q.delete();
    exp_word_q.delete();
    exp_bwe--;
    exp_done--;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_bwe", 160'(total_bwe), 160'(bwe_before));
    txn(1'b1, 1'b0, 32'h0000_3004, 32'h0);
    check("midrst_next_read", 160'({t_nbwe, t_done0}), 160'({32'd1, 32'd5}));

    // randomized refills with stalls and stray acks
    pat_a0 = 1'b0;
    ack_delay = -1;
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      txn(1'b1, 1'b0, ra, 32'h0);
      check("rand_one_bwe", 160'(t_nbwe), 160'd1);
      if ((n % 8) == 7) begin
        rw = $urandom;
        txn(1'b0, 1'b1, $urandom, rw);
        check("rand_wr_no_bwe", 160'(t_nbwe), 160'd0);
      end
    end
    repeat (4) @(negedge clk);

    check("final_bwe_total", 160'(total_bwe), 160'(exp_bwe));
    check("final_done_total", 160'(total_done), 160'(exp_done));
    check("final_queues_empty", 160'(exp_blk_q.size() + exp_word_q.size() + exp_wr_q.size()), 160'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
